// File: rtl/muller_c_handshake_monitor.sv
// -----------------------------------------------------------------------------
// muller_c_handshake_monitor
//
// Watches a Muller C-element stage from a synchronous clock domain. The two
// C-element inputs and its output are resynchronised, then a four-phase
// protocol FSM checks that the output only moves once both inputs agree, and
// that it does so within TIMEOUT cycles of them agreeing.
//
// Ports
//   clk, rst_n   monitor clock, async active-low reset
//   a_i, b_i     C-element inputs (asynchronous)
//   c_i          C-element output (asynchronous)
//   clr_i        sync clear of cycle counter and error state (FSM untouched)
//   c_sync_o     synchronised C level
//   rise_o       1-cycle pulse on synchronised C rising edge
//   fall_o       1-cycle pulse on synchronised C falling edge
//   cycles_o     completed legal handshakes, wraps silently
//   busy_o       FSM waiting for C to follow the inputs (ARM_HI / ARM_LO)
//   err_o        sticky error flag
//   err_code_o   first error seen: 00 none, 01 spurious C edge, 10 timeout
// -----------------------------------------------------------------------------

// One synchroniser lane: STAGES-deep flop chain, async cleared.
module muller_c_sync_lane #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic [STAGES-1:0] chain;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) chain <= '0;
        else        chain <= {chain[STAGES-2:0], d};
    end

    assign q = chain[STAGES-1];
endmodule

module muller_c_handshake_monitor #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 16,
    parameter int TIMEOUT     = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a_i,
    input  logic             b_i,
    input  logic             c_i,
    input  logic             clr_i,
    output logic             c_sync_o,
    output logic             rise_o,
    output logic             fall_o,
    output logic [CNT_W-1:0] cycles_o,
    output logic             busy_o,
    output logic             err_o,
    output logic [1:0]       err_code_o
);
    localparam int               TMR_W    = 8;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_SPUR = 2'b01;
    localparam logic [1:0] ERR_TMO  = 2'b10;

    typedef enum logic [1:0] {
        IDLE_LO = 2'd0,
        ARM_HI  = 2'd1,
        HOLD_HI = 2'd2,
        ARM_LO  = 2'd3
    } state_t;

    // ---------------------------------------------------------------- sync
    logic [2:0] async_in;
    logic [2:0] sync_q;

    assign async_in = {c_i, b_i, a_i};

    for (genvar g = 0; g < 3; g++) begin : g_sync
        muller_c_sync_lane #(.STAGES(SYNC_STAGES)) u_lane (
            .clk   (clk),
            .rst_n (rst_n),
            .d     (async_in[g]),
            .q     (sync_q[g])
        );
    end

    logic a_s, b_s, c_s, c_q;
    logic rise, fall;

    assign a_s  = sync_q[0];
    assign b_s  = sync_q[1];
    assign c_s  = sync_q[2];
    assign rise = c_s & ~c_q;
    assign fall = ~c_s & c_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_q    <= 1'b0;
            rise_o <= 1'b0;
            fall_o <= 1'b0;
        end else begin
            c_q    <= c_s;
            rise_o <= rise;
            fall_o <= fall;
        end
    end

    assign c_sync_o = c_s;

    // ----------------------------------------------------------------- FSM
    state_t           state, state_d;
    logic [TMR_W-1:0] timer, timer_d;
    logic             new_err;
    logic [1:0]       new_code;
    logic             cyc_inc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE_LO;
            timer <= '0;
        end else begin
            state <= state_d;
            timer <= timer_d;
        end
    end

    // Edge checks come first in every state: a C edge beats both arm entry
    // (spurious) and the timeout. Error exits always land in the state that
    // matches the current C level.
    always_comb begin
        state_d  = state;
        timer_d  = timer;
        new_err  = 1'b0;
        new_code = ERR_NONE;
        cyc_inc  = 1'b0;
        case (state)
            IDLE_LO: begin
                if (rise) begin
                    new_err  = 1'b1;
                    new_code = ERR_SPUR;
                    state_d  = HOLD_HI;
                end else if (a_s && b_s) begin
                    state_d = ARM_HI;
                    timer_d = '0;
                end
            end
            ARM_HI: begin
                if (rise) begin
                    state_d = HOLD_HI;
                end else if (!(a_s && b_s)) begin
                    state_d = IDLE_LO;
                end else if (timer == TMR_LAST) begin
                    new_err  = 1'b1;
                    new_code = ERR_TMO;
                    state_d  = IDLE_LO;
                end else begin
                    timer_d = timer + TMR_W'(1);
                end
            end
            HOLD_HI: begin
                if (fall) begin
                    new_err  = 1'b1;
                    new_code = ERR_SPUR;
                    state_d  = IDLE_LO;
                end else if (!a_s && !b_s) begin
                    state_d = ARM_LO;
                    timer_d = '0;
                end
            end
            ARM_LO: begin
                if (fall) begin
                    state_d = IDLE_LO;
                    cyc_inc = 1'b1;
                end else if (a_s || b_s) begin
                    state_d = HOLD_HI;
                end else if (timer == TMR_LAST) begin
                    new_err  = 1'b1;
                    new_code = ERR_TMO;
                    state_d  = HOLD_HI;
                end else begin
                    timer_d = timer + TMR_W'(1);
                end
            end
            default: state_d = IDLE_LO;
        endcase
    end

    assign busy_o = (state == ARM_HI) || (state == ARM_LO);

    // ------------------------------------------------- counter and errors
    // A new error outranks clr_i; when both land together the new code is
    // taken even if an older error was pending.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_o      <= 1'b0;
            err_code_o <= ERR_NONE;
            cycles_o   <= '0;
        end else begin
            if (new_err) begin
                err_o <= 1'b1;
                if (clr_i || !err_o) err_code_o <= new_code;
            end else if (clr_i) begin
                err_o      <= 1'b0;
                err_code_o <= ERR_NONE;
            end

            if (clr_i)        cycles_o <= '0;
            else if (cyc_inc) cycles_o <= cycles_o + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_muller_c_handshake_monitor.sv
module tb_muller_c_handshake_monitor;
    localparam int S  = 2;
    localparam int CW = 3;
    localparam int TO = 15;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          a, b, c, clr;
    logic          c_sync_o, rise_o, fall_o, busy_o, err_o;
    logic [CW-1:0] cycles_o;
    logic [1:0]    err_code_o;

    int checks = 0;
    int errors = 0;

    muller_c_handshake_monitor #(.SYNC_STAGES(S), .CNT_W(CW), .TIMEOUT(TO)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .a_i        (a),
        .b_i        (b),
        .c_i        (c),
        .clr_i      (clr),
        .c_sync_o   (c_sync_o),
        .rise_o     (rise_o),
        .fall_o     (fall_o),
        .cycles_o   (cycles_o),
        .busy_o     (busy_o),
        .err_o      (err_o),
        .err_code_o (err_code_o)
    );

    always #5 clk = ~clk;

    // Reference model. The protocol is symmetric: the monitor rests at a C
    // level, "arms" once the inputs agree on the opposite level, and the
    // awaited edge is the one leaving the current level.
    bit qa[$], qb[$], qc[$];
    bit m_cq, m_rise, m_fall;
    bit m_level, m_armed;
    int m_age, m_cycles, m_code;
    bit m_err;

    task automatic model_reset();
        qa = {}; qb = {}; qc = {};
        for (int i = 0; i < S; i++) begin
            qa.push_back(1'b0); qb.push_back(1'b0); qc.push_back(1'b0);
        end
        m_cq = 0; m_rise = 0; m_fall = 0;
        m_level = 0; m_armed = 0; m_age = 0;
        m_cycles = 0; m_err = 0; m_code = 0;
    endtask

    task automatic model_update();
        bit ma, mb, mc, rs, fl, edg, want, nerr, inc;
        int code;
        ma = qa[S-1]; mb = qb[S-1]; mc = qc[S-1];
        rs = mc & ~m_cq;
        fl = ~mc & m_cq;
        edg  = m_level ? fl : rs;
        want = m_level ? (!ma && !mb) : (ma && mb);
        nerr = 0; inc = 0; code = 0;
        if (!m_armed) begin
            if (edg) begin
                nerr = 1; code = 1; m_level = !m_level;
            end else if (want) begin
                m_armed = 1; m_age = 0;
            end
        end else begin
            if (edg) begin
                if (m_level) inc = 1;
                m_level = !m_level; m_armed = 0;
            end else if (!want) begin
                m_armed = 0;
            end else if (m_age == TO - 1) begin
                nerr = 1; code = 2; m_armed = 0;
            end else begin
                m_age++;
            end
        end
        if (nerr) begin
            if (clr || !m_err) m_code = code;
            m_err = 1;
        end else if (clr) begin
            m_err = 0; m_code = 0;
        end
        if (clr)      m_cycles = 0;
        else if (inc) m_cycles = (m_cycles + 1) % (1 << CW);
        m_rise = rs;
        m_fall = fl;
        m_cq   = mc;
        qa.push_front(a); void'(qa.pop_back());
        qb.push_front(b); void'(qb.pop_back());
        qc.push_front(c); void'(qc.pop_back());
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("c_sync", 32'(c_sync_o), 32'(qc[S-1]));
        chk("rise",   32'(rise_o),   32'(m_rise));
        chk("fall",   32'(fall_o),   32'(m_fall));
        chk("busy",   32'(busy_o),   32'(m_armed));
        chk("err",    32'(err_o),    32'(m_err));
        chk("code",   32'(err_code_o), 32'(m_code));
        chk("cycles", 32'(cycles_o), 32'(m_cycles));
    endtask

    // Inputs are changed at the falling edge; outputs sampled 1 after rising.
    task automatic step();
        @(posedge clk);
        if (!rst_n) model_reset();
        else        model_update();
        #1 check_all();
        @(negedge clk);
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic handshake();
        a = 1; b = 1; steps(4);
        c = 1;        steps(4);
        a = 0; b = 0; steps(4);
        c = 0;        steps(4);
    endtask

    task automatic pulse_clr();
        clr = 1; step(); clr = 0;
    endtask

    initial begin
        rst_n = 0; a = 0; b = 0; c = 0; clr = 0;
        model_reset();
        #1 check_all();
        chk("rst_cycles", 32'(cycles_o), 32'd0);
        chk("rst_code",   32'(err_code_o), 32'd0);
        steps(2);
        rst_n = 1;

        // legal handshake
        handshake();
        chk("hs_cycles", 32'(cycles_o), 32'd1);
        chk("hs_err",    32'(err_o), 32'd0);

        // legal cancel from ARM_HI
        a = 1; b = 1; steps(3);
        chk("cancel_busy_hi", 32'(busy_o), 32'd1);
        a = 0; steps(4);
        chk("cancel_busy_lo", 32'(busy_o), 32'd0);
        chk("cancel_err",     32'(err_o), 32'd0);

        // spurious rise, then a later timeout keeps the first code
        a = 1; b = 0; c = 1; steps(4);
        chk("spur_err",  32'(err_o), 32'd1);
        chk("spur_code", 32'(err_code_o), 32'd1);
        chk("spur_csync", 32'(c_sync_o), 32'd1);
        a = 0; steps(20);
        chk("spur_tmo_code", 32'(err_code_o), 32'd1);
        c = 0; steps(4);

        // timeout in ARM_HI, FSM re-arms
        pulse_clr();
        a = 1; b = 1; steps(20);
        chk("tmo_code", 32'(err_code_o), 32'd2);
        chk("tmo_err",  32'(err_o), 32'd1);
        chk("tmo_rearm", 32'(busy_o), 32'd1);
        a = 0; b = 0; steps(4);

        // counter wrap: 9 handshakes on a 3-bit counter
        pulse_clr();
        for (int i = 0; i < 9; i++) handshake();
        chk("wrap_cycles", 32'(cycles_o), 32'd1);

        // clr in the same cycle as a spurious edge: error wins
        a = 1; b = 0; c = 1; steps(2);
        clr = 1; step(); clr = 0;
        chk("clr_spur_err",  32'(err_o), 32'd1);
        chk("clr_spur_code", 32'(err_code_o), 32'd1);

        // reset mid-ARM_LO, C still high when released
        a = 0; steps(3);
        chk("arm_lo_busy", 32'(busy_o), 32'd1);
        rst_n = 0;
        #1 model_reset();
        check_all();
        steps(2);
        rst_n = 1;
        steps(8);
        chk("post_rst_code", 32'(err_code_o), 32'd1);
        c = 0; steps(4);

        // randomized phase: C mostly behaves like a C-element, sometimes not
        for (int n = 0; n < 300; n++) begin
            int sel;
            sel = $urandom_range(0, 3);
            if (sel == 0)      a = ~a;
            else if (sel == 1) b = ~b;
            else begin a = 1'($urandom_range(0, 1)); b = 1'($urandom_range(0, 1)); end
            for (int i = $urandom_range(0, 5); i > 0; i--) begin
                clr = ($urandom_range(0, 29) == 0); step();
            end
            if ($urandom_range(0, 9) == 0)       c = ~c;
            else if (a == b && $urandom_range(0, 7) != 0) c = a;
            for (int i = $urandom_range(1, ($urandom_range(0, 9) == 0) ? 18 : 6); i > 0; i--) begin
                clr = ($urandom_range(0, 29) == 0); step();
            end
            clr = 0;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
